// File: rtl/adma_pkg.sv
// Shared ADMA definitions: descriptor field positions, ACT and error encodings,
// one-hot state encoding and descriptor sizes for both address widths.
package adma_pkg;

   localparam int DESC_VALID_BIT = 0;
   localparam int DESC_END_BIT   = 1;
   localparam int DESC_INT_BIT   = 2;
   localparam int DESC_ACT_LSB   = 4;
   localparam int DESC_LEN_LSB   = 16;

   localparam logic [63:0] DESC_SIZE_32 = 64'd8;
   localparam logic [63:0] DESC_SIZE_64 = 64'd12;

   typedef enum logic [1:0] {
      ACT_NOP  = 2'b00,
      ACT_RSV  = 2'b01,
      ACT_TRAN = 2'b10,
      ACT_LINK = 2'b11
   } act_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_INVALID = 2'b01,
      ERR_RSV     = 2'b10,
      ERR_LOOP    = 2'b11
   } err_e;

   typedef enum logic [8:0] {
      ST_IDLE       = 9'b0_0000_0001,
      ST_FETCH_W0   = 9'b0_0000_0010,
      ST_FETCH_W1   = 9'b0_0000_0100,
      ST_FETCH_W2   = 9'b0_0000_1000,
      ST_DECODE     = 9'b0_0001_0000,
      ST_XFER_START = 9'b0_0010_0000,
      ST_XFER_WAIT  = 9'b0_0100_0000,
      ST_NEXT       = 9'b0_1000_0000,
      ST_ERROR      = 9'b1_0000_0000
   } state_e;

   typedef struct packed {
      logic        eop;
      logic        irq;
      act_e        act;
      logic [15:0] length;
      logic [63:0] addr;
      err_e        err;
   } desc_t;

endpackage

// File: rtl/adma_desc_decode.sv
// Combinational descriptor field extract and validity check.
// `ADMA_DESC_64BIT_EN` adds the third word carrying ADDR[63:32].
module adma_desc_decode
   import adma_pkg::*;
(
   input  logic [31:0] word0,
   input  logic [31:0] word1,
`ifdef ADMA_DESC_64BIT_EN
   input  logic [31:0] word2,
`endif
   output desc_t       desc
);

   logic unused_bits;
   assign unused_bits = ^{word0[15:6], word0[3]};

   always_comb begin
      desc        = '0;
      desc.eop    = word0[DESC_END_BIT];
      desc.irq    = word0[DESC_INT_BIT];
      desc.act    = act_e'(word0[DESC_ACT_LSB +: 2]);
      desc.length = word0[DESC_LEN_LSB +: 16];
`ifdef ADMA_DESC_64BIT_EN
      desc.addr   = {word2, word1};
`else
      desc.addr   = {32'h0, word1};
`endif
      if (!word0[DESC_VALID_BIT])
         desc.err = ERR_INVALID;
      else if (desc.act == ACT_RSV)
         desc.err = ERR_RSV;
      else
         desc.err = ERR_NONE;
   end

endmodule

// File: rtl/adma_desc_fetch.sv
// ADMA2 descriptor-table walker: fetches, decodes and dispatches descriptors to transfer.
// `ADMA_DESC_64BIT_EN` selects 12-byte descriptors with 64-bit data/LINK addresses.
module adma_desc_fetch
   import adma_pkg::*;
#(
   parameter logic [15:0] MAX_DESC = 16'hFFFF
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        adma_start,
   input  logic        adma_stop,
   input  logic        direction,
   input  logic [63:0] desc_base,
   output logic        ram_read,
   output logic [63:0] ram_address,
   input  logic        ram_ack,
   input  logic [31:0] data_from_ram,
   output logic        xfer_start,
   output logic        xfer_direction,
   output logic [63:0] xfer_address,
   output logic [15:0] xfer_length,
   input  logic        xfer_tfc,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic        int_req,
   output logic [63:0] desc_ptr
);

`ifdef ADMA_DESC_64BIT_EN
   localparam logic [63:0] DESC_SIZE = DESC_SIZE_64;
`else
   localparam logic [63:0] DESC_SIZE = DESC_SIZE_32;
`endif

   state_e      state;
   logic [31:0] word0_q, word1_q;
`ifdef ADMA_DESC_64BIT_EN
   logic [31:0] word2_q;
`endif
   logic [15:0] desc_cnt, cnt_nx;
   logic [63:0] ptr_nx;
   logic        tfc_low_seen;
   desc_t       dsc;

   assign cnt_nx = desc_cnt + 16'd1;
   assign ptr_nx = desc_ptr + DESC_SIZE;

   adma_desc_decode u_decode (
      .word0 (word0_q),
      .word1 (word1_q),
`ifdef ADMA_DESC_64BIT_EN
      .word2 (word2_q),
`endif
      .desc  (dsc)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state          <= ST_IDLE;
         ram_read       <= 1'b0;
         ram_address    <= '0;
         xfer_start     <= 1'b0;
         xfer_direction <= 1'b0;
         xfer_address   <= '0;
         xfer_length    <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         err_code       <= 2'b00;
         int_req        <= 1'b0;
         desc_ptr       <= '0;
         desc_cnt       <= '0;
         tfc_low_seen   <= 1'b0;
         word0_q        <= '0;
         word1_q        <= '0;
`ifdef ADMA_DESC_64BIT_EN
         word2_q        <= '0;
`endif
      end else begin
         xfer_start <= 1'b0;
         done       <= 1'b0;
         int_req    <= 1'b0;
         // Stop beats everything, including a read acknowledged in the same cycle.
         if (adma_stop && state != ST_IDLE) begin
            state    <= ST_IDLE;
            ram_read <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: if (adma_start) begin
                  desc_ptr    <= desc_base;
                  desc_cnt    <= '0;
                  error       <= 1'b0;
                  err_code    <= 2'b00;
                  busy        <= 1'b1;
                  ram_read    <= 1'b1;
                  ram_address <= desc_base;
                  state       <= ST_FETCH_W0;
               end
               ST_FETCH_W0: if (ram_ack) begin
                  word0_q     <= data_from_ram;
                  ram_address <= desc_ptr + 64'd4;
                  state       <= ST_FETCH_W1;
               end
               ST_FETCH_W1: if (ram_ack) begin
                  word1_q <= data_from_ram;
`ifdef ADMA_DESC_64BIT_EN
                  ram_address <= desc_ptr + 64'd8;
                  state       <= ST_FETCH_W2;
`else
                  ram_read <= 1'b0;
                  state    <= ST_DECODE;
`endif
               end
`ifdef ADMA_DESC_64BIT_EN
               ST_FETCH_W2: if (ram_ack) begin
                  word2_q  <= data_from_ram;
                  ram_read <= 1'b0;
                  state    <= ST_DECODE;
               end
`endif
               ST_DECODE: begin
                  if (dsc.err != ERR_NONE) begin
                     error    <= 1'b1;
                     err_code <= dsc.err;
                     state    <= ST_ERROR;
                  end else begin
                     case (dsc.act)
                        ACT_TRAN: begin
                           xfer_address   <= dsc.addr;
                           xfer_length    <= dsc.length;
                           xfer_direction <= direction;
                           xfer_start     <= 1'b1;
                           state          <= ST_XFER_START;
                        end
                        // LINKs count toward the loop limit so a self-linked table terminates.
                        ACT_LINK: begin
                           desc_cnt <= cnt_nx;
                           if (cnt_nx == MAX_DESC) begin
                              error    <= 1'b1;
                              err_code <= ERR_LOOP;
                              state    <= ST_ERROR;
                           end else begin
                              desc_ptr    <= dsc.addr;
                              ram_read    <= 1'b1;
                              ram_address <= dsc.addr;
                              state       <= ST_FETCH_W0;
                           end
                        end
                        default: state <= ST_NEXT;
                     endcase
                  end
               end
               ST_XFER_START: begin
                  tfc_low_seen <= 1'b0;
                  state        <= ST_XFER_WAIT;
               end
               // transfer idles with TFC high, so only a rising TFC after a low counts.
               ST_XFER_WAIT: begin
                  if (xfer_tfc && tfc_low_seen)
                     state <= ST_NEXT;
                  else if (!xfer_tfc)
                     tfc_low_seen <= 1'b1;
               end
               ST_NEXT: begin
                  int_req <= dsc.irq;
                  if (dsc.eop) begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else begin
                     desc_ptr <= ptr_nx;
                     desc_cnt <= cnt_nx;
                     if (cnt_nx == MAX_DESC) begin
                        error    <= 1'b1;
                        err_code <= ERR_LOOP;
                        state    <= ST_ERROR;
                     end else begin
                        ram_read    <= 1'b1;
                        ram_address <= ptr_nx;
                        state       <= ST_FETCH_W0;
                     end
                  end
               end
               ST_ERROR: begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: begin
                  ram_read <= 1'b0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/adma_desc_fetch.md
# adma_desc_fetch

ADMA2 descriptor-table engine for the SD host controller's ADMA block. It walks a descriptor table in system RAM: fetching, decoding and validating each descriptor. For every TRAN descriptor it launches one `transfer` operation, handing over the start pulse, address and length, then waits for that operation's transfer-complete before moving to the next descriptor. It sits directly upstream of `transfer` and shares the RAM port with it through an external arbiter.

## Interface
- `MAX_DESC`, 16'hFFFF: descriptors processed per run before a loop error is flagged.
- `CLK` in 1: single system clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `adma_start` in 1: one-cycle pulse that begins a run; ignored unless the block is in IDLE.
- `adma_stop` in 1: abort request; honoured in any non-IDLE state.
- `direction` in 1: 0 = FIFO→RAM, 1 = RAM→FIFO; forwarded unchanged.
- `desc_base` in 64: address of the first descriptor; must be 4-byte aligned.
- `ram_read` out 1: descriptor read request; held until `ram_ack`.
- `ram_address` out 64: descriptor word address.
- `ram_ack` in 1: read data is valid on `data_from_ram` in this cycle.
- `data_from_ram` in 32: descriptor word.
- `xfer_start` out 1: one-cycle start pulse to `transfer`.
- `xfer_direction` out 1: copy of `direction`.
- `xfer_address` out 64: data address from the descriptor.
- `xfer_length` out 16: length field, forwarded verbatim.
- `xfer_tfc` in 1: transfer-complete from `transfer`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after an END descriptor completes.
- `error` out 1: sticky error flag; cleared by the next `adma_start`.
- `err_code` out 2: 01 = invalid descriptor, 10 = reserved act, 11 = loop limit.
- `int_req` out 1: one-cycle pulse on completion of a descriptor whose INT bit is set.
- `desc_ptr` out 64: address of the current descriptor, for the ADMA system-address register.

## Operation
- Descriptor word 0 fields:
  - [0] VALID, [1] END, [2] INT.
  - [5:4] ACT: 00 NOP, 01 RSV, 10 TRAN, 11 LINK.
  - [31:16] LENGTH.
- Word 1 holds ADDR[31:0]. Upper address bits are zero unless the configuration option below is enabled.
- States: IDLE, FETCH_W0, FETCH_W1, (FETCH_W2), DECODE, XFER_START, XFER_WAIT, NEXT, ERROR.
- IDLE:
  - On `adma_start`: `desc_ptr` ← `desc_base`, descriptor counter ← 0, `error` cleared.
  - Go to FETCH_W0.
- FETCH_Wn:
  - Assert `ram_read` with `ram_address` = `desc_ptr` + 4n.
  - Latch the word on `ram_ack`, then advance.
- DECODE:
  - VALID=0 → ERROR, code 01.
  - ACT=RSV → ERROR, code 10.
  - ACT=NOP → NEXT.
  - ACT=TRAN → XFER_START.
  - ACT=LINK → `desc_ptr` ← ADDR, then FETCH_W0. END is ignored on a LINK descriptor.
- XFER_START: drive `xfer_start` high for exactly one cycle, then go to XFER_WAIT.
- XFER_WAIT:
  - `transfer` idles with TFC=1, so completion is the first cycle with `xfer_tfc`=1 after `xfer_tfc`=0 has been seen at least once.
  - Completion → NEXT.
- NEXT:
  - Pulse `int_req` if INT was set.
  - If END: pulse `done`, go to IDLE.
  - Otherwise: `desc_ptr` += descriptor size, counter += 1. If counter reaches `MAX_DESC` → ERROR, code 11; else → FETCH_W0.
- ERROR: `error` is held and `busy` falls one cycle later; the state returns to IDLE.
- `adma_stop` in any non-IDLE state:
  - Go to IDLE on the next edge and drop `ram_read`.
  - No `done` pulse; `error` is unchanged.
- Address arithmetic is 64-bit modulo 2^64; wrap-around is not flagged.

## Timing
- Reset values:
  - All 1-bit outputs = 0.
  - `err_code` = 0.
  - `desc_ptr`, `ram_address`, `xfer_address` = 0.
  - `xfer_length` = 0.
  - State = IDLE.
- `xfer_address`, `xfer_length` and `xfer_direction` are registered in DECODE and stable from the `xfer_start` cycle until the next DECODE.
- Latency from `adma_start` to `xfer_start` is 4 cycles + RAM wait cycles (with `ram_ack` in the cycle after the request: 6 cycles).
- `adma_start` while `busy` is ignored.
- If `adma_stop` and `ram_ack` arrive in the same cycle, stop wins and the data is discarded.
- If `adma_stop` arrives in XFER_WAIT, the block does not wait for TFC; `transfer` is left to finish on its own.

## Configuration
- Macro `ADMA_DESC_64BIT_EN`.
- Defined:
  - Descriptors are 12 bytes; FETCH_W2 reads ADDR[63:32].
  - `desc_ptr` advances by 12.
  - LINK targets are 64-bit.
- Undefined:
  - Descriptors are 8 bytes and FETCH_W2 does not exist.
  - ADDR[63:32] = 0 and `desc_ptr` advances by 8.

## Structure
- Shared package `adma_pkg` holds:
  - ACT encodings and descriptor bit positions.
  - Error codes.
  - State encoding (one-hot, 5+ bits, matching `transfer`'s style).
  - Descriptor size constants for both configurations.
- One sub-module, `adma_desc_decode`: a combinational field extract plus validity check, feeding DECODE.

## Test plan
- Single TRAN {VALID,END,ACT=10,LEN=0x0010} at base 0x1000, ADDR=0x8000 → one `xfer_start` with address 0x8000 and length 0x0010; `done` pulses after the TFC 0→1 edge.
- NOP, then TRAN, then TRAN+END+INT at 0x2000 → two `xfer_start` pulses, `desc_ptr` ends at 0x2010 (0x2018 with 64-bit enabled), and `int_req` and `done` pulse in the same cycle.
- LINK at 0x1000 → 0x3000, where a TRAN+END sits → RAM reads at 0x1000, 0x1004, 0x3000, 0x3004; LINK's END bit ignored.
- VALID=0 descriptor → `error`=1, `err_code`=01, no `xfer_start`, `busy` low 2 cycles after DECODE.
- Self-LINK loop with `MAX_DESC`=4 → `err_code`=11; also `adma_stop` during FETCH_W1 with a simultaneous `ram_ack` → IDLE, no `done`.
- `RESET` asserted mid-XFER_WAIT → all outputs 0 immediately; the next `adma_start` runs normally.
